cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter ORDER, default 3: number of integrator stages and comb stages (legal 1..5).
REQ-002 Parameter MAX_R, default 64: largest decimation ratio supported (legal 2..256).
REQ-003 Parameter OUT_BITS, default 16: output word width.
REQ-004 Parameter BIPOLAR, default 0: 0 maps input bit to 0/1; 1 maps it to -1/+1.
REQ-005 clk  input  1  single rising-edge clock.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  qualifies in_bit; a sample is accepted on each rising edge with in_valid=1.
REQ-008 in_bit  input  1  modulator bitstream sample.
REQ-009 ratio  input  RW=clog2(MAX_R+1)  requested decimation ratio R, sampled only at frame boundaries.
REQ-010 out_data  output  OUT_BITS  two's-complement decimated sample.
REQ-011 out_valid  output  1  one-cycle strobe marking a new out_data.
REQ-012 settling  output  1  high while warm-up outputs are being suppressed.

Function
REQ-013 ACC_BITS SHALL be ORDER*clog2(MAX_R)+2; all integrator, comb and delay registers SHALL be ACC_BITS wide and wrap modulo 2^ACC_BITS.
REQ-014 Input value SHALL be x = in_bit (BIPOLAR=0) or x = in_bit ? +1 : -1 (BIPOLAR=1), sign-extended to ACC_BITS.
REQ-015 On each accepted sample, integrator 1 SHALL add x; integrator k (k>1) SHALL add the updated value of integrator k-1, all in the same edge (cascade on next values).
REQ-016 With in_valid=0, no integrator, counter or comb SHALL change.
REQ-017 A sample counter SHALL count accepted samples 0..R_eff-1; the edge accepting count R_eff-1 SHALL end the frame, wrap the counter to 0 and set an internal tick register.
REQ-018 On the edge after tick is set, the comb chain SHALL run once: stage k output = input - delay_k, delay_k <= input, stage 1 input = final integrator register.
REQ-019 out_data SHALL update on that same edge and out_valid SHALL be high for exactly the following cycle (latency: 2 edges from last frame sample to out_valid).
REQ-020 Output scaling: if ACC_BITS > OUT_BITS, out_data = comb result bits [ACC_BITS-1 : ACC_BITS-OUT_BITS]; otherwise out_data = comb result sign-extended.
REQ-021 R_eff SHALL be ratio clamped to range 2..MAX_R (ratio 0/1 -> 2; ratio > MAX_R -> MAX_R).
REQ-022 R_eff SHALL be loaded at reset exit and at each frame end only; mid-frame ratio changes SHALL have no effect until the next frame.
REQ-023 When a frame-end load changes R_eff, integrators SHALL keep running and the warm-up counter SHALL restart.
REQ-024 Warm-up: after reset exit or an R_eff change, the first ORDER comb results SHALL update out_data but SHALL NOT assert out_valid; settling is high until the (ORDER+1)th result.
REQ-025 A frame end coinciding with a pending tick SHALL NOT occur (R_eff>=2); a frame end with in_valid held high for consecutive frames SHALL produce one out_valid per R_eff samples with no loss.

Reset
REQ-026 While rst_n=0 at a rising edge, all integrators, delays, counters, tick and out_data SHALL clear to 0; out_valid SHALL be 0; settling SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release starts frame count 0 with R_eff loaded from ratio.

Structure
REQ-028 Package cic_pkg SHALL hold the clog2 function, the ACC_BITS/RW derivation and the R clamp limits.
REQ-029 One sub-module cic_comb_stage (ACC_BITS wide, enable, one delay register, subtract) SHALL be instantiated ORDER times via generate; integrators stay inline.

Verification
REQ-030 ORDER=2, R=4, BIPOLAR=0, in_bit=1 continuous -> after 2 suppressed outputs, every out_valid shows out_data=16 (0x0010), one per 4 samples.
REQ-031 Same config, BIPOLAR=1, in_bit=0 continuous -> steady out_data=-16 (0xFFF0); in_bit alternating 1,0 -> steady 0.
REQ-032 ORDER=2, ratio switched 4->8 mid-frame with all-ones input -> current frame completes at 4 samples, settling re-asserts, 2 outputs suppressed, then steady 64 every 8 samples.
REQ-033 in_valid toggled 1,0,1,0 with all-ones, R=4 -> output values identical to continuous case; spacing 8 cycles.
REQ-034 ratio=0 and ratio=MAX_R+5 -> frame lengths 2 and MAX_R respectively.
REQ-035 rst_n pulsed low for one edge mid-frame -> out_valid=0, out_data=0, settling=1 next cycle; recovery identical to power-on sequence.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC decimator and its comb stages.
package cic_pkg;

    localparam int R_MIN = 2;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return bits;
    endfunction

    // Worst-case CIC gain is R^ORDER; two guard bits cover the sign and bipolar input.
    function automatic int acc_bits(input int order, input int max_r);
        return order * clog2(max_r) + 2;
    endfunction

    function automatic int ratio_bits(input int max_r);
        return clog2(max_r + 1);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x[previous frame], delay updated only when enabled.
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] delay_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_q <= '0;
        end else if (en) begin
            delay_q <= din;
        end
    end

    assign dout = din - delay_q;

endmodule

// File: rtl/cic_decimator.sv
// Bitstream CIC decimator: ORDER integrators at input rate, ORDER combs at frame rate,
// runtime ratio with frame-aligned reload and warm-up suppression.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int ORDER    = 3,
    parameter int MAX_R    = 64,
    parameter int OUT_BITS = 16,
    parameter int BIPOLAR  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_bit,
    input  logic [ratio_bits(MAX_R)-1:0]  ratio,
    output logic [OUT_BITS-1:0]           out_data,
    output logic                          out_valid,
    output logic                          settling
);

    localparam int ACC_BITS = acc_bits(ORDER, MAX_R);
    localparam int RW       = ratio_bits(MAX_R);
    localparam int WARM_W   = clog2(ORDER + 1);

    localparam logic [RW-1:0]     R_LO      = RW'(R_MIN);
    localparam logic [RW-1:0]     R_HI      = RW'(MAX_R);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);

    typedef logic [ACC_BITS-1:0] acc_t;

    acc_t              x;
    acc_t              carry;
    acc_t              integ_q [ORDER];
    acc_t              integ_d [ORDER];
    acc_t              comb_out;
    logic [OUT_BITS-1:0] scaled;
    logic [RW-1:0]     ratio_clamped;
    logic [RW-1:0]     r_eff_q;
    logic [RW-1:0]     cnt_q;
    logic [WARM_W-1:0] warm_q;
    logic              tick_q;
    logic              frame_end;
    logic              r_change;

    always_comb begin
        ratio_clamped = ratio;
        if (ratio < R_LO) begin
            ratio_clamped = R_LO;
        end else if (ratio > R_HI) begin
            ratio_clamped = R_HI;
        end
    end

    always_comb begin
        if (BIPOLAR != 0) begin
            x = in_bit ? acc_t'(1) : '1;
        end else begin
            x = acc_t'(in_bit);
        end
    end

    // NOTE: blocking assignments here are intentional -- carry ripples through the
    // cascade so each integrator adds the already-updated value of the one before it.
    always_comb begin
        carry = x;
        for (int k = 0; k < ORDER; k++) begin
            carry      = integ_q[k] + carry;
            integ_d[k] = carry;
        end
    end

    assign frame_end = in_valid && (cnt_q == r_eff_q - RW'(1));
    assign r_change  = frame_end && (ratio_clamped != r_eff_q);

    // NOTE: the integrator array is a handful of registers, not a RAM, so it is
    // cleared element by element like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            r_eff_q <= ratio_clamped;
        end else begin
            tick_q <= frame_end;
            if (in_valid) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[k] <= integ_d[k];
                end
                cnt_q <= frame_end ? '0 : cnt_q + RW'(1);
            end
            if (frame_end) begin
                r_eff_q <= ratio_clamped;
            end
        end
    end

    for (genvar g = 0; g < ORDER; g++) begin : gen_comb
        acc_t stage_in;
        acc_t stage_out;
        if (g == 0) begin : g_first
            assign stage_in = integ_q[ORDER-1];
        end else begin : g_next
            assign stage_in = gen_comb[g-1].stage_out;
        end
        cic_comb_stage #(.W(ACC_BITS)) u_comb (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (tick_q),
            .din  (stage_in),
            .dout (stage_out)
        );
    end

    assign comb_out = gen_comb[ORDER-1].stage_out;

    if (ACC_BITS > OUT_BITS) begin : g_trunc
        logic unused_lsbs;
        assign scaled      = comb_out[ACC_BITS-1 -: OUT_BITS];
        assign unused_lsbs = ^comb_out[ACC_BITS-OUT_BITS-1:0];
    end else begin : g_sext
        assign scaled = OUT_BITS'($signed(comb_out));
    end

    // Warm-up restarts on a ratio change; frame end and tick never share an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            settling  <= 1'b1;
            warm_q    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (tick_q) begin
                out_data <= scaled;
                if (warm_q < WARM_DONE) begin
                    warm_q <= warm_q + WARM_W'(1);
                end else begin
                    out_valid <= 1'b1;
                    settling  <= 1'b0;
                end
            end
            if (r_change) begin
                warm_q   <= '0;
                settling <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench: unipolar and bipolar decimators (ORDER=2, MAX_R=64) on shared stimulus.
module tb_cic_decimator;

    localparam int ORDER    = 2;
    localparam int MAX_R    = 64;
    localparam int OUT_BITS = 16;
    localparam int RW       = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_bit = 1'b0;
    logic [RW-1:0]       ratio = 7'd4;
    logic [OUT_BITS-1:0] out_data_u, out_data_b;
    logic                out_valid_u, out_valid_b;
    logic                settling_u, settling_b;

    int n_cmp = 0;
    int n_err = 0;
    int vmode = 0;
    int bmode = 0;
    int phase_cnt = 0;
    bit fixed_bit = 1'b1;
    int n;

    always #5 clk = ~clk;

    cic_decimator #(.ORDER(ORDER), .MAX_R(MAX_R), .OUT_BITS(OUT_BITS), .BIPOLAR(0)) u_uni (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .ratio(ratio),
        .out_data(out_data_u), .out_valid(out_valid_u), .settling(settling_u)
    );

    cic_decimator #(.ORDER(ORDER), .MAX_R(MAX_R), .OUT_BITS(OUT_BITS), .BIPOLAR(1)) u_bip (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .ratio(ratio),
        .out_data(out_data_b), .out_valid(out_valid_b), .settling(settling_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // vmode 1 toggles in_valid starting high; bmode 1 alternates in_bit starting at 1.
    task automatic step();
        in_valid = (vmode == 0) ? 1'b1 : ~phase_cnt[0];
        in_bit   = (bmode != 0) ? ~phase_cnt[0] : fixed_bit;
        phase_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [RW-1:0] r, input int vm, input int bm, input bit b);
        ratio    = r;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        vmode     = vm;
        bmode     = bm;
        fixed_bit = b;
        phase_cnt = 0;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (out_valid_u === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        // Power-on: R=4, all ones
        reset_dut(7'd4, 0, 0, 1'b1);
        check("rst_valid", 32'(out_valid_u), 32'd0);
        check("rst_data", 32'(out_data_u), 32'd0);
        check("rst_settling", 32'(settling_u), 32'd1);
        check("rst_settling_bip", 32'(settling_b), 32'd1);
        repeat (5) step();
        check("warm1_data", 32'(out_data_u), 32'd10);
        check("warm1_valid", 32'(out_valid_u), 32'd0);
        check("warm1_settling", 32'(settling_u), 32'd1);
        wait_valid(20, n);
        check("ones_first_edge", 32'(n), 32'd8);
        check("ones_data_uni", 32'(out_data_u), 32'h0010);
        check("ones_data_bip", 32'(out_data_b), 32'h0010);
        check("ones_settled", 32'(settling_u), 32'd0);
        step();
        check("valid_one_cycle", 32'(out_valid_u), 32'd0);
        wait_valid(10, n);
        check("ones_spacing", 32'(n), 32'd3);
        check("ones_data2", 32'(out_data_u), 32'h0010);

        // All zeros: bipolar -> -16, unipolar -> 0
        reset_dut(7'd4, 0, 0, 1'b0);
        wait_valid(20, n);
        check("zeros_first_edge", 32'(n), 32'd13);
        check("zeros_data_bip", 32'(out_data_b), 32'hFFF0);
        check("zeros_data_uni", 32'(out_data_u), 32'h0000);
        check("zeros_valid_bip", 32'(out_valid_b), 32'd1);
        wait_valid(10, n);
        check("zeros_spacing", 32'(n), 32'd4);
        check("zeros_data_bip2", 32'(out_data_b), 32'hFFF0);

        // Alternating 1,0: bipolar -> 0, unipolar -> 8
        reset_dut(7'd4, 0, 1, 1'b0);
        wait_valid(20, n);
        check("alt_first_edge", 32'(n), 32'd13);
        check("alt_data_bip", 32'(out_data_b), 32'h0000);
        check("alt_data_uni", 32'(out_data_u), 32'h0008);
        wait_valid(10, n);
        check("alt_data_bip2", 32'(out_data_b), 32'h0000);

        // in_valid toggling: same values, doubled spacing
        reset_dut(7'd4, 1, 0, 1'b1);
        wait_valid(40, n);
        check("gap_first_edge", 32'(n), 32'd24);
        check("gap_data", 32'(out_data_u), 32'h0010);
        wait_valid(20, n);
        check("gap_spacing", 32'(n), 32'd8);
        check("gap_data2", 32'(out_data_u), 32'h0010);

        // Ratio 4 -> 8 mid-frame
        reset_dut(7'd4, 0, 0, 1'b1);
        wait_valid(20, n);
        check("sw_first_edge", 32'(n), 32'd13);
        ratio = 7'd8;
        repeat (3) step();
        check("sw_settling_up", 32'(settling_u), 32'd1);
        step();
        check("sw_old_frame_data", 32'(out_data_u), 32'h0010);
        check("sw_old_frame_valid", 32'(out_valid_u), 32'd0);
        wait_valid(40, n);
        check("sw_new_first_edge", 32'(n), 32'd16);
        check("sw_data", 32'(out_data_u), 32'h0040);
        check("sw_settled", 32'(settling_u), 32'd0);
        wait_valid(20, n);
        check("sw_spacing", 32'(n), 32'd8);
        check("sw_data_bip", 32'(out_data_b), 32'h0040);

        // Ratio clamping: 0 -> 2, MAX_R+5 -> MAX_R
        reset_dut(7'd0, 0, 0, 1'b1);
        wait_valid(20, n);
        check("r0_first_edge", 32'(n), 32'd7);
        check("r0_data", 32'(out_data_u), 32'h0004);
        wait_valid(10, n);
        check("r0_spacing", 32'(n), 32'd2);
        reset_dut(7'(MAX_R + 5), 0, 0, 1'b1);
        wait_valid(250, n);
        check("rmax_first_edge", 32'(n), 32'd193);
        check("rmax_data", 32'(out_data_u), 32'h1000);
        wait_valid(100, n);
        check("rmax_spacing", 32'(n), 32'd64);

        // One-edge reset pulse mid-frame, then power-on recovery
        reset_dut(7'd4, 0, 0, 1'b1);
        wait_valid(20, n);
        check("pulse_pre_edge", 32'(n), 32'd13);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check("pulse_valid", 32'(out_valid_u), 32'd0);
        check("pulse_data", 32'(out_data_u), 32'd0);
        check("pulse_settling", 32'(settling_u), 32'd1);
        rst_n     = 1'b1;
        phase_cnt = 0;
        repeat (5) step();
        check("pulse_warm1_data", 32'(out_data_u), 32'd10);
        wait_valid(20, n);
        check("pulse_first_edge", 32'(n), 32'd8);
        check("pulse_data_after", 32'(out_data_u), 32'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
